cola_dispenser: RTL and testbench

//  Dispense-side responder for the vending controller's cola strobe. Accepts
//  1-cycle cola requests and queues them, with per-request stock reservation.

---
 rtl/cola_pkg.sv | 12 +
 rtl/cola_timer.sv | 21 ++
 rtl/cola_dispenser.sv | 93 +++++++++
 tb/tb_cola_dispenser.sv | 119 +++++++++++
 4 files changed

// File: rtl/cola_pkg.sv
// cola_pkg: shared state encodings and default timing/stock parameters for the cola dispenser
package cola_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    DISP = 3'b010,
    GAP  = 3'b100
  } state_t;
  localparam int MOTOR_CYCLES_DEF = 50;
  localparam int GAP_CYCLES_DEF   = 10;
  localparam int STOCK_MAX_DEF    = 8;
  localparam int PEND_DEPTH_DEF   = 4;
endpackage

// File: rtl/cola_timer.sv
// cola_timer: loadable down-counter that parks at zero, shared by the motor and gap phases
module cola_timer
  import cola_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  // load takes priority; otherwise count down and hold at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_value;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/cola_dispenser.sv
// cola_dispenser: queues cola requests against reserved stock, runs the motor per can, then a cool-down gap
module cola_dispenser
  import cola_pkg::*;
#(
  parameter int  MOTOR_CYCLES = MOTOR_CYCLES_DEF,
  parameter int  GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int  STOCK_MAX    = STOCK_MAX_DEF,
  parameter int  PEND_DEPTH   = PEND_DEPTH_DEF,
  localparam int STOCK_W      = $clog2(STOCK_MAX + 1),
  localparam int PEND_W       = $clog2(PEND_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pi_cola,
  input  logic               pi_refill,
  output logic               po_motor,
  output logic               po_served,
  output logic               po_refund,
  output logic               po_busy,
  output logic               po_empty,
  output logic [STOCK_W-1:0] po_stock
);
  localparam int TMAX = (MOTOR_CYCLES > GAP_CYCLES) ? MOTOR_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t              r_state, w_next;
  logic [PEND_W-1:0]   r_pend;
  logic [STOCK_W-1:0]  r_stock;
  logic                r_served, r_refund;
  logic                w_accept, w_start, w_load, w_zero;
  logic [TW-1:0]       w_value;

  // a request is accepted only if queue has room and every queued request still has a can reserved
  assign w_accept = pi_cola && (32'(r_pend) < PEND_DEPTH) && (32'(r_stock) > 32'(r_pend));
  assign w_start  = (r_state == IDLE) && (r_pend != '0);

  cola_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_value (w_value),
    .o_zero  (w_zero)
  );

  // next-state and timer-load decode; unknown encodings fall back to IDLE
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_value = '0;
    case (r_state)
      IDLE: if (r_pend != '0) begin
        w_next  = DISP;
        w_load  = 1'b1;
        w_value = TW'(MOTOR_CYCLES - 1);
      end
      DISP: if (w_zero) begin
        w_next  = GAP;
        w_load  = 1'b1;
        w_value = TW'(GAP_CYCLES - 1);
      end
      GAP: if (w_zero) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  // queue count, stock (refill overrides, dispense start still consumes), and one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= '0;
      r_stock  <= STOCK_W'(STOCK_MAX);
      r_served <= 1'b0;
      r_refund <= 1'b0;
    end else begin
      r_pend   <= r_pend + PEND_W'(w_accept) - PEND_W'(w_start);
      r_stock  <= (pi_refill ? STOCK_W'(STOCK_MAX) : r_stock) - STOCK_W'(w_start);
      r_served <= (r_state == DISP) && w_zero;
      r_refund <= pi_cola && !w_accept;
    end
  end

  assign po_motor  = (r_state == DISP);
  assign po_served = r_served;
  assign po_refund = r_refund;
  assign po_busy   = (r_state != IDLE) || (r_pend != '0);
  assign po_empty  = (r_stock == '0);
  assign po_stock  = r_stock;
endmodule

// File: tb/tb_cola_dispenser.sv
// tb_cola_dispenser: directed cycle-by-cycle checks of queueing, stock, refill and reset behaviour
module tb_cola_dispenser;
  logic       clk = 1'b0, rst_n = 1'b0, pi_cola = 1'b0, pi_refill = 1'b0;
  logic       po_motor, po_served, po_refund, po_busy, po_empty;
  logic [1:0] po_stock;
  int         checks = 0, errors = 0;
  logic [4:0] ex;
  int         st;

  always #5 clk = ~clk;

  cola_dispenser #(
    .MOTOR_CYCLES(5), .GAP_CYCLES(3), .STOCK_MAX(3), .PEND_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pi_cola(pi_cola), .pi_refill(pi_refill),
    .po_motor(po_motor), .po_served(po_served), .po_refund(po_refund),
    .po_busy(po_busy), .po_empty(po_empty), .po_stock(po_stock)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  function automatic logic rng(input int k, input int a, input int b);
    return k >= a && k <= b;
  endfunction

  wire [4:0] outs = {po_motor, po_served, po_refund, po_busy, po_empty};

  initial begin
    // reset state
    repeat (3) step();
    chk("reset_outs", 0, outs, 5'b00000);
    chk("reset_stock", 0, {3'b0, po_stock}, 5'd3);
    rst_n = 1'b1;

    // single request at k=0: motor k2..6, served k7, idle from k10
    for (int k = 0; k < 12; k++) begin
      ex = {rng(k, 2, 6), k == 7, 1'b0, rng(k, 1, 9), 1'b0};
      st = k >= 2 ? 2 : 3;
      chk("single_outs", k, outs, ex);
      chk("single_stock", k, {3'b0, po_stock}, 5'(st));
      pi_cola = (k == 0);
      step();
    end
    pi_cola = 1'b0;

    // refill back to 3, then four requests: fourth rejected on full queue, three cans 9 cycles apart
    pi_refill = 1'b1;
    step();
    pi_refill = 1'b0;
    for (int k = 0; k < 30; k++) begin
      ex = {rng(k, 2, 6) | rng(k, 11, 15) | rng(k, 20, 24), k == 7 || k == 16 || k == 25,
            k == 4, rng(k, 1, 27), k >= 20};
      st = k < 2 ? 3 : k < 11 ? 2 : k < 20 ? 1 : 0;
      chk("burst_outs", k, outs, ex);
      chk("burst_stock", k, {3'b0, po_stock}, 5'(st));
      pi_cola = (k < 4);
      step();
    end
    pi_cola = 1'b0;

    // request while empty: refund only
    for (int k = 0; k < 5; k++) begin
      chk("empty_outs", k, outs, {1'b0, 1'b0, k == 1, 1'b0, 1'b1});
      chk("empty_stock", k, {3'b0, po_stock}, 5'd0);
      pi_cola = (k == 0);
      step();
    end
    pi_cola = 1'b0;

    // refill+request (rejected on old stock), accepted request, refill at dispense start, refill mid-DISP
    for (int k = 0; k < 22; k++) begin
      ex = {rng(k, 3, 7) | rng(k, 12, 16), k == 8 || k == 17, k == 1, rng(k, 2, 19), k == 0};
      st = k == 0 ? 0 : k < 3 ? 3 : k < 14 ? 2 : 3;
      chk("refill_outs", k, outs, ex);
      chk("refill_stock", k, {3'b0, po_stock}, 5'(st));
      pi_cola   = (k == 0 || k == 1 || k == 3);
      pi_refill = (k == 0 || k == 11 || k == 13);
      step();
    end
    pi_cola   = 1'b0;
    pi_refill = 1'b0;

    // two requests, then async reset in the third motor cycle
    for (int k = 0; k < 4; k++) begin
      chk("prereset_outs", k, outs, {rng(k, 2, 3), 1'b0, 1'b0, k >= 1, 1'b0});
      chk("prereset_stock", k, {3'b0, po_stock}, 5'(k < 2 ? 3 : 2));
      pi_cola = (k <= 1);
      step();
    end
    pi_cola = 1'b0;
    chk("motor_run3", 4, outs, 5'b10010);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 0, outs, 5'b00000);
    chk("async_reset_stock", 0, {3'b0, po_stock}, 5'd3);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      chk("postreset_outs", k, outs, 5'b00000);
      chk("postreset_stock", k, {3'b0, po_stock}, 5'd3);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
